// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and round-robin helper for the RAM port arbiter
// Contents:
//   TAG_IDW   : id field width carried in pipeline tags (covers up to MAX_REQ requesters)
//   MAX_REQ   : largest requester count the helper function can handle
//   ram_tag_t : {valid, id} descriptor for one RAM read pipeline stage
//   rr_next   : one-hot round-robin pick starting after the last winner
package ram_arb_pkg;

    localparam int TAG_IDW = 6;
    localparam int MAX_REQ = 1 << TAG_IDW;

    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } ram_tag_t;

    // Scan last+1, last+2, ... wrapping at n; the first asserted valid wins.
    // Returns all-zero when nothing is requesting.
    function automatic logic [MAX_REQ-1:0] rr_next(
        input logic [TAG_IDW-1:0] last,
        input logic [MAX_REQ-1:0] valid,
        input int                 n
    );
        logic [MAX_REQ-1:0] grant;
        logic [TAG_IDW:0]   idx;
        logic               found;
        grant = '0;
        found = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            if (i <= n) begin
                idx = {1'b0, last} + (TAG_IDW+1)'(i);
                if (idx >= (TAG_IDW+1)'(n)) begin
                    idx = idx - (TAG_IDW+1)'(n);
                end
                if (!found && valid[idx[TAG_IDW-1:0]]) begin
                    grant[idx[TAG_IDW-1:0]] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/ram_block.sv
// rtl/ram_block.sv - dual-port RAM with two-stage registered read, ce-gated per port
// Ports (N = 1, 2):
//   clk    : clock
//   ceN    : port enable; when low the port's read registers and writes hold
//   weN    : write enable (qualified by ceN)
//   addrN  : address, AWIDTH+1 bits
//   dN     : write data
//   qN     : read data, two enabled cycles after the address
module ram_block #(
    parameter int DWIDTH   = 8,
    parameter int AWIDTH   = 13,
    parameter int MEM_SIZE = 3072
) (
    input  logic              clk,
    input  logic              ce1,
    input  logic              we1,
    input  logic [AWIDTH:0]   addr1,
    input  logic [DWIDTH-1:0] d1,
    output logic [DWIDTH-1:0] q1,
    input  logic              ce2,
    input  logic              we2,
    input  logic [AWIDTH:0]   addr2,
    input  logic [DWIDTH-1:0] d2,
    output logic [DWIDTH-1:0] q2
);

    localparam int IW = $clog2(MEM_SIZE);

    logic [DWIDTH-1:0] mem [0:MEM_SIZE-1];
    logic [DWIDTH-1:0] s1;
    logic [DWIDTH-1:0] s2;

    wire unused_addr_hi = ^{addr1[AWIDTH:IW], addr2[AWIDTH:IW]};

    always_ff @(posedge clk) begin
        if (ce1) begin
            if (we1) begin
                mem[addr1[IW-1:0]] <= d1;
            end
            s1 <= mem[addr1[IW-1:0]];
            q1 <= s1;
        end
        if (ce2) begin
            if (we2) begin
                mem[addr2[IW-1:0]] <= d2;
            end
            s2 <= mem[addr2[IW-1:0]];
            q2 <= s2;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter owning the last-winner pointer
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   req       : per-requester request lines
//   en        : arbitration enable; grant is all-zero while low
//   grant     : one-hot winner (or zero)
//   grant_id  : binary index of the winner (0 when no grant)
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_id
);

    logic [IDW-1:0]     last;
    logic [MAX_REQ-1:0] grant_ext;

    always_comb begin
        grant_ext = '0;
        if (en) begin
            grant_ext = rr_next(TAG_IDW'(last), MAX_REQ'(req), NUM_REQ);
        end
        grant    = grant_ext[NUM_REQ-1:0];
        grant_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_id = IDW'(i);
            end
        end
    end

    wire unused_grant_hi = ^grant_ext[MAX_REQ-1:NUM_REQ];

    // Reset to NUM_REQ-1 so requester 0 is scanned first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= IDW'(NUM_REQ - 1);
        end else if (en && |req) begin
            last <= grant_id;
        end
    end

endmodule

// File: rtl/ram_block_arbiter.sv
// rtl/ram_block_arbiter.sv - round-robin sharing of one ram_block port with in-order read return
// Ports:
//   clk, rst                          : clock, asynchronous active-high reset
//   req_valid/req_ready               : per-requester handshake (ready is one-hot or zero)
//   req_we/req_addr/req_wdata         : per-requester command
//   rsp_valid/rsp_ready               : read response handshake
//   rsp_data/rsp_id                   : read data and originating requester
//   ram_addr/ram_ce/ram_we/ram_d/ram_q: connection to one ram_block port
module ram_block_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DWIDTH  = 8,
    parameter int AWIDTH  = 13,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ-1:0][AWIDTH:0]   req_addr,
    input  logic [NUM_REQ-1:0][DWIDTH-1:0] req_wdata,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [DWIDTH-1:0]              rsp_data,
    output logic [IDW-1:0]                 rsp_id,
    output logic [AWIDTH:0]                ram_addr,
    output logic                           ram_ce,
    output logic                           ram_we,
    output logic [DWIDTH-1:0]              ram_d,
    input  logic [DWIDTH-1:0]              ram_q
);

    // tag0 tracks the RAM's first read register, tag1 tracks ram_q.
    ram_tag_t            tag0;
    ram_tag_t            tag1;
    logic                stall;
    logic                arb_en;
    logic                transfer;
    logic [NUM_REQ-1:0]  grant;
    logic [IDW-1:0]      g;
    logic [AWIDTH:0]     addr_hold;
    logic [DWIDTH-1:0]   d_hold;

    // A response sitting in ram_q that nobody takes freezes the whole
    // read pipeline, RAM registers included, so nothing is overwritten.
    assign stall  = tag1.valid & ~rsp_ready;
    assign ram_ce = ~stall;
    // Keep grants (and hence RAM writes) off while reset is asserted.
    assign arb_en = ~stall & ~rst;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_arbiter (
        .clk      (clk),
        .rst      (rst),
        .req      (req_valid),
        .en       (arb_en),
        .grant    (grant),
        .grant_id (g)
    );

    assign req_ready = grant;
    assign transfer  = |grant;

    // Writes must land at the end of the grant cycle, so the RAM command is
    // muxed straight from the winner; idle cycles replay the last address/data.
    assign ram_we   = transfer & req_we[g];
    assign ram_addr = transfer ? req_addr[g]  : addr_hold;
    assign ram_d    = transfer ? req_wdata[g] : d_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_hold <= '0;
            d_hold    <= '0;
        end else if (transfer) begin
            addr_hold <= req_addr[g];
            d_hold    <= req_wdata[g];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag0 <= '0;
            tag1 <= '0;
        end else if (!stall) begin
            tag1       <= tag0;
            tag0.valid <= transfer & ~req_we[g];
            tag0.id    <= TAG_IDW'(g);
        end
    end

    assign rsp_valid = tag1.valid;
    assign rsp_data  = ram_q;
    assign rsp_id    = tag1.id[IDW-1:0];

    wire unused_tag_hi = ^tag1.id[TAG_IDW-1:IDW];

endmodule

// File: tb/tb_ram_block_arbiter.sv
// tb/tb_ram_block_arbiter.sv - directed self-checking bench for ram_block_arbiter
module tb_ram_block_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DWIDTH  = 8;
    localparam int AWIDTH  = 13;
    localparam int IDW     = 2;

    logic                           clk;
    logic                           rst;
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             req_we;
    logic [NUM_REQ-1:0][AWIDTH:0]   req_addr;
    logic [NUM_REQ-1:0][DWIDTH-1:0] req_wdata;
    logic                           rsp_valid;
    logic                           rsp_ready;
    logic [DWIDTH-1:0]              rsp_data;
    logic [IDW-1:0]                 rsp_id;
    logic [AWIDTH:0]                ram_addr;
    logic                           ram_ce;
    logic                           ram_we;
    logic [DWIDTH-1:0]              ram_d;
    logic [DWIDTH-1:0]              ram_q;
    logic [DWIDTH-1:0]              q2_unused;

    int n_checks = 0;
    int n_fail   = 0;

    ram_block_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DWIDTH  (DWIDTH),
        .AWIDTH  (AWIDTH),
        .IDW     (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .ram_addr  (ram_addr),
        .ram_ce    (ram_ce),
        .ram_we    (ram_we),
        .ram_d     (ram_d),
        .ram_q     (ram_q)
    );

    ram_block #(
        .DWIDTH   (DWIDTH),
        .AWIDTH   (AWIDTH),
        .MEM_SIZE (3072)
    ) u_ram (
        .clk   (clk),
        .ce1   (ram_ce),
        .we1   (ram_we),
        .addr1 (ram_addr),
        .d1    (ram_d),
        .q1    (ram_q),
        .ce2   (1'b0),
        .we2   (1'b0),
        .addr2 ('0),
        .d2    ('0),
        .q2    (q2_unused)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_all();
        req_valid = '0;
        req_we    = '0;
    endtask

    task automatic drive(input int i, input logic we, input int addr, input logic [7:0] d);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = 14'(addr);
        req_wdata[i] = d;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_checks++;
        if (ram_ce !== 1'b1) begin n_fail++; $display("FAIL reset_ram_ce: got %b expected 1", ram_ce); end
        n_checks++;
        if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        req_valid = 4'b1111;
        req_we    = 4'b1111;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready_busy: got %b expected 0000", req_ready); end
        n_checks++;
        if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we: got %b expected 0", ram_we); end
        idle_all();
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_fairness();
        logic [3:0] exp;
        int cnt [4];
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0;
            drive(i, 1'b1, 100 + i, 8'(8'h40 + i));
        end
        for (int c = 0; c < 8; c++) begin
            #1;
            exp = 4'b0001 << (c % 4);
            n_checks++;
            if (req_ready !== exp) begin n_fail++; $display("FAIL fair_order c=%0d: got %b expected %b", c, req_ready, exp); end
            for (int i = 0; i < 4; i++) cnt[i] += int'(req_ready[i]);
            step();
        end
        idle_all();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (cnt[i] != 2) begin n_fail++; $display("FAIL fair_count r%0d: got %0d expected 2", i, cnt[i]); end
        end
    endtask

    task automatic test_single_read();
        idle_all();
        drive(2, 1'b1, 5, 8'hA5);
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_wr_ready: got %b expected 0100", req_ready); end
        n_checks++;
        if (ram_we !== 1'b1 || ram_addr !== 14'd5 || ram_d !== 8'hA5) begin
            n_fail++; $display("FAIL single_wr_ram: got we=%b addr=%0d d=%h expected we=1 addr=5 d=a5", ram_we, ram_addr, ram_d);
        end
        step();
        drive(2, 1'b0, 5, 8'h00);
        #1;
        n_checks++;
        if (req_ready !== 4'b0100 || ram_we !== 1'b0) begin n_fail++; $display("FAIL single_rd_ready: got %b we=%b expected 0100 we=0", req_ready, ram_we); end
        step();
        idle_all();
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got rsp_valid %b expected 0", rsp_valid); end
        step();
        #1;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'hA5 || rsp_id !== 2'd2) begin
            n_fail++; $display("FAIL single_rsp: got v=%b d=%h id=%0d expected v=1 d=a5 id=2", rsp_valid, rsp_data, rsp_id);
        end
        step();
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_after: got rsp_valid %b expected 0", rsp_valid); end
        step();
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        for (int i = 0; i < 10; i++) begin
            idle_all();
            drive(1, 1'b1, i, 8'(8'h30 + i));
            step();
        end
        idle_all();
        step();
        step();
        for (int k = 0; k < 14; k++) begin
            idle_all();
            if (k < 10) drive(1, 1'b0, k, 8'h00);
            #1;
            n_checks++;
            if (req_ready !== ((k < 10) ? 4'b0010 : 4'b0000)) begin n_fail++; $display("FAIL b2b_ready k=%0d: got %b", k, req_ready); end
            exp_v = (k >= 2 && k < 12);
            n_checks++;
            if (rsp_valid !== exp_v) begin n_fail++; $display("FAIL b2b_valid k=%0d: got %b expected %b", k, rsp_valid, exp_v); end
            if (exp_v) begin
                n_checks++;
                if (rsp_data !== 8'(8'h30 + k - 2) || rsp_id !== 2'd1) begin
                    n_fail++; $display("FAIL b2b_rsp k=%0d: got d=%h id=%0d expected d=%h id=1", k, rsp_data, rsp_id, 8'(8'h30 + k - 2));
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_rdy [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000,
                                     4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
        logic       exp_v   [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
        logic [7:0] exp_d   [10] = '{8'h00, 8'h00, 8'h30, 8'h31, 8'h31,
                                     8'h31, 8'h31, 8'h31, 8'h32, 8'h00};
        logic       rr;
        int delivered = 0;
        for (int k = 0; k < 10; k++) begin
            idle_all();
            if (k < 3) drive(0, 1'b0, k, 8'h00);
            else if (k < 8) drive(3, 1'b1, 200, 8'h77);
            rr = !(k >= 3 && k <= 6);
            rsp_ready = rr;
            #1;
            n_checks++;
            if (req_ready !== exp_rdy[k]) begin n_fail++; $display("FAIL bp_ready k=%0d: got %b expected %b", k, req_ready, exp_rdy[k]); end
            n_checks++;
            if (ram_ce !== rr) begin n_fail++; $display("FAIL bp_ce k=%0d: got %b expected %b", k, ram_ce, rr); end
            n_checks++;
            if (rsp_valid !== exp_v[k]) begin n_fail++; $display("FAIL bp_valid k=%0d: got %b expected %b", k, rsp_valid, exp_v[k]); end
            if (exp_v[k]) begin
                n_checks++;
                if (rsp_data !== exp_d[k] || rsp_id !== 2'd0) begin
                    n_fail++; $display("FAIL bp_data k=%0d: got d=%h id=%0d expected d=%h id=0", k, rsp_data, rsp_id, exp_d[k]);
                end
            end
            if (rsp_valid === 1'b1 && rr) delivered++;
            step();
        end
        rsp_ready = 1'b1;
        idle_all();
        n_checks++;
        if (delivered != 3) begin n_fail++; $display("FAIL bp_delivered: got %0d expected 3", delivered); end
    endtask

    task automatic test_writes_no_rsp();
        int pulses = 0;
        logic exp_v;
        for (int k = 0; k < 10; k++) begin
            idle_all();
            case (k)
                0: drive(0, 1'b1, 300, 8'h11);
                1: drive(1, 1'b0, 200, 8'h00);
                2: drive(2, 1'b1, 301, 8'h22);
                3: drive(3, 1'b1, 302, 8'h33);
                4: drive(0, 1'b0, 300, 8'h00);
                5: drive(1, 1'b1, 303, 8'h44);
                default: ;
            endcase
            #1;
            exp_v = (k == 3 || k == 6);
            n_checks++;
            if (rsp_valid !== exp_v) begin n_fail++; $display("FAIL wr_valid k=%0d: got %b expected %b", k, rsp_valid, exp_v); end
            if (k == 3) begin
                n_checks++;
                if (rsp_data !== 8'h77 || rsp_id !== 2'd1) begin n_fail++; $display("FAIL wr_rsp1: got d=%h id=%0d expected d=77 id=1", rsp_data, rsp_id); end
            end
            if (k == 6) begin
                n_checks++;
                if (rsp_data !== 8'h11 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL wr_rsp2: got d=%h id=%0d expected d=11 id=0", rsp_data, rsp_id); end
            end
            if (rsp_valid === 1'b1) pulses++;
            step();
        end
        n_checks++;
        if (pulses != 2) begin n_fail++; $display("FAIL wr_pulses: got %0d expected 2", pulses); end
    endtask

    task automatic test_reset_midflight();
        logic [7:0] exp_d [4] = '{8'h5A, 8'h30, 8'h31, 8'h32};
        logic [3:0] exp_r;
        idle_all();
        drive(0, 1'b1, 400, 8'h5A);
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_wr_ready: got %b expected 0001", req_ready); end
        step();
        idle_all();
        drive(2, 1'b0, 400, 8'h00);
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL rst_rd_ready: got %b expected 0100", req_ready); end
        step();
        idle_all();
        rst = 1'b1;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || ram_ce !== 1'b1) begin n_fail++; $display("FAIL rst_in_reset: got v=%b ce=%b expected v=0 ce=1", rsp_valid, ram_ce); end
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_rsp k=%0d: got %b expected 0", k, rsp_valid); end
            step();
        end
        req_we      = '0;
        req_addr[0] = 14'd400;
        req_addr[1] = 14'd0;
        req_addr[2] = 14'd1;
        req_addr[3] = 14'd2;
        for (int k = 0; k < 8; k++) begin
            req_valid = (k < 4) ? (4'b1111 << k) : 4'b0000;
            #1;
            exp_r = (k < 4) ? (4'b0001 << k) : 4'b0000;
            n_checks++;
            if (req_ready !== exp_r) begin n_fail++; $display("FAIL rst_after_grant k=%0d: got %b expected %b", k, req_ready, exp_r); end
            if (k >= 2 && k < 6) begin
                n_checks++;
                if (rsp_valid !== 1'b1 || rsp_data !== exp_d[k-2] || rsp_id !== 2'(k - 2)) begin
                    n_fail++; $display("FAIL rst_after_rsp k=%0d: got v=%b d=%h id=%0d expected v=1 d=%h id=%0d", k, rsp_valid, rsp_data, rsp_id, exp_d[k-2], k - 2);
                end
            end else begin
                n_checks++;
                if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_after_idle k=%0d: got %b expected 0", k, rsp_valid); end
            end
            step();
        end
        idle_all();
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single_read();
        test_back_to_back();
        test_backpressure();
        test_writes_no_rsp();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
